// File: rtl/data_cache_if.sv
// ---------------------------------------------------------------------------
// data_cache_if
// Bus bundle for data_cache: Memory-stage pipeline side plus backing-memory
// side, grouped into one interface.
//   Pipeline side : MemReadM, MemWriteM, AddrM, WriteDataM -> cache
//                   ReadDataM, StallM                     <- cache
//   Memory side   : mem_req, mem_we, mem_addr, mem_wdata   <- cache
//                   mem_ready, mem_rvalid, mem_rdata      -> cache
// Modports:
//   master : the environment (pipeline register + DataMemory)
//   slave  : the cache itself
// ---------------------------------------------------------------------------
interface data_cache_if #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned MEM_ADDR_WIDTH = 17
);
    logic                      MemReadM;
    logic                      MemWriteM;
    logic [ADDR_WIDTH-1:0]     AddrM;
    logic [DATA_WIDTH-1:0]     WriteDataM;
    logic [DATA_WIDTH-1:0]     ReadDataM;
    logic                      StallM;

    logic                      mem_req;
    logic                      mem_we;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic                      mem_ready;
    logic                      mem_rvalid;
    logic [DATA_WIDTH-1:0]     mem_rdata;

    modport master (
        output MemReadM, MemWriteM, AddrM, WriteDataM,
        input  ReadDataM, StallM,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  MemReadM, MemWriteM, AddrM, WriteDataM,
        output ReadDataM, StallM,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/data_cache.sv
// ---------------------------------------------------------------------------
// data_cache
// Direct-mapped, write-through, no-write-allocate L1 data cache sitting
// between the Memory-stage pipeline register and DataMemory.
//   - Load hits return data combinationally in the same cycle.
//   - Load misses fill the whole line (LINE_WORDS reads) while StallM is high.
//   - Stores are written through to memory; a hit also updates the cached
//     word, a miss does not allocate.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : data_cache_if.slave (pipeline and backing-memory signals)
//   hit_count / miss_count : 32-bit saturating load statistics, present only
//                            when CACHE_STATS_EN is defined
// Build option: define CACHE_STATS_EN to add the statistics counters/ports.
// ---------------------------------------------------------------------------
module data_cache #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned MEM_ADDR_WIDTH = 17,
    parameter int unsigned NUM_LINES      = 16,
    parameter int unsigned LINE_WORDS     = 4
) (
    input  logic          clk,
    input  logic          rst,
    data_cache_if.slave   bus
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]   hit_count,
    output logic [31:0]   miss_count
`endif
);

    localparam int unsigned OFF_W = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = MEM_ADDR_WIDTH - 2 - OFF_W - IDX_W;
    localparam int unsigned CNT_W = OFF_W + 1;

    localparam logic [CNT_W-1:0] CNT_LW   = CNT_W'(LINE_WORDS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_WRITE
    } state_t;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_data [NUM_LINES*LINE_WORDS];
    logic [TAG_W-1:0]      r_tag  [NUM_LINES];
    logic [NUM_LINES-1:0]  r_valid;

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      r_req_cnt;   // fill reads accepted by memory
    logic [CNT_W-1:0]      r_ret_cnt;   // fill words returned
    logic [DATA_WIDTH-1:0] r_rdata;     // last load result, held when idle
    logic                  r_wr_done;   // store just completed this cycle
    logic                  r_fill_done; // fill just completed this cycle

    // ------------------------------------------------------------------
    // Address decode (only the bits DataMemory decodes take part)
    // ------------------------------------------------------------------
    logic [MEM_ADDR_WIDTH-1:0]     w_maddr;
    logic [OFF_W-1:0]              w_off;
    logic [IDX_W-1:0]              w_idx;
    logic [TAG_W-1:0]              w_tag;
    logic [MEM_ADDR_WIDTH-3-OFF_W:0] w_line_hi;
    logic                          w_hit;
    logic [DATA_WIDTH-1:0]         w_word;
    logic                          w_unused_addr;

    assign w_maddr   = bus.AddrM[MEM_ADDR_WIDTH-1:0];
    assign w_off     = w_maddr[2 +: OFF_W];
    assign w_idx     = w_maddr[2+OFF_W +: IDX_W];
    assign w_tag     = w_maddr[MEM_ADDR_WIDTH-1 -: TAG_W];
    assign w_line_hi = w_maddr[MEM_ADDR_WIDTH-1:2+OFF_W];
    assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_word    = r_data[{w_idx, w_off}];

    assign w_unused_addr = ^{bus.AddrM[ADDR_WIDTH-1:MEM_ADDR_WIDTH], bus.AddrM[1:0]};

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    logic                      w_stall;
    logic                      w_mem_req;
    logic                      w_mem_we;
    logic [MEM_ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0]     w_mem_wdata;
    logic                      w_rd_hit;     // load hit served this cycle
    logic                      w_rd_miss;    // load miss classified this cycle
    logic                      w_fill_we;    // accept a fill return word
    logic                      w_fill_last;  // final word of the line
    logic                      w_wr_hit_we;  // write-through also updates line
    logic                      w_req_acc;    // fill read accepted by memory

    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_addr   = '0;
        w_mem_wdata  = '0;
        w_rd_hit     = 1'b0;
        w_rd_miss    = 1'b0;
        w_fill_we    = 1'b0;
        w_fill_last  = 1'b0;
        w_wr_hit_we  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (bus.MemWriteM) begin
                    // The pipeline only advances past the store at the end of
                    // the IDLE cycle after WRITE, so the same store is still
                    // presented here and must not be issued a second time.
                    if (!r_wr_done) begin
                        w_stall      = 1'b1;
                        w_next_state = S_WRITE;
                    end
                end else if (bus.MemReadM) begin
                    if (w_hit) begin
                        w_rd_hit = 1'b1;
                    end else begin
                        // The first line read goes out in the miss cycle
                        // itself, which gives the LINE_WORDS+1 minimum penalty.
                        w_rd_miss    = 1'b1;
                        w_stall      = 1'b1;
                        w_mem_req    = 1'b1;
                        w_mem_addr   = {w_line_hi, r_req_cnt[OFF_W-1:0], 2'b00};
                        w_next_state = S_FILL;
                    end
                end
            end

            S_FILL: begin
                w_stall = 1'b1;
                if (r_req_cnt < CNT_LW) begin
                    w_mem_req  = 1'b1;
                    w_mem_addr = {w_line_hi, r_req_cnt[OFF_W-1:0], 2'b00};
                end
                // Returns are in order; a return with nothing outstanding
                // (stale after reset) is dropped.
                if (bus.mem_rvalid && (r_ret_cnt < r_req_cnt)) begin
                    w_fill_we = 1'b1;
                    if (r_ret_cnt == CNT_LAST) begin
                        w_fill_last  = 1'b1;
                        w_next_state = S_IDLE;
                    end
                end
            end

            S_WRITE: begin
                w_stall     = 1'b1;
                w_mem_req   = 1'b1;
                w_mem_we    = 1'b1;
                w_mem_addr  = {w_maddr[MEM_ADDR_WIDTH-1:2], 2'b00};
                w_mem_wdata = bus.WriteDataM;
                if (bus.mem_ready) begin
                    w_wr_hit_we  = w_hit;
                    w_next_state = S_IDLE;
                end
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign w_req_acc = w_mem_req && !w_mem_we && bus.mem_ready;

    assign bus.StallM    = w_stall;
    assign bus.mem_req   = w_mem_req;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.ReadDataM = w_rd_hit ? w_word : r_rdata;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_req_cnt   <= '0;
            r_ret_cnt   <= '0;
            r_valid     <= '0;
            r_rdata     <= '0;
            r_wr_done   <= 1'b0;
            r_fill_done <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_wr_done   <= (r_state == S_WRITE) && bus.mem_ready;
            r_fill_done <= w_fill_last;

            if (w_fill_last) begin
                r_req_cnt <= '0;
                r_ret_cnt <= '0;
            end else begin
                if (w_req_acc) begin
                    r_req_cnt <= r_req_cnt + CNT_ONE;
                end
                if (w_fill_we) begin
                    r_ret_cnt <= r_ret_cnt + CNT_ONE;
                end
            end

            // The line is rewritten word by word during the fill, so it is
            // invalid until the last word lands.
            if (w_rd_miss) begin
                r_valid[w_idx] <= 1'b0;
            end else if (w_fill_last) begin
                r_valid[w_idx] <= 1'b1;
            end

            if (w_rd_hit) begin
                r_rdata <= w_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // Data and tag arrays (not reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_data[{w_idx, r_ret_cnt[OFF_W-1:0]}] <= bus.mem_rdata;
        end else if (w_wr_hit_we) begin
            r_data[{w_idx, w_off}] <= bus.WriteDataM;
        end
        if (w_fill_last) begin
            r_tag[w_idx] <= w_tag;
        end
    end

`ifdef CACHE_STATS_EN
    // ------------------------------------------------------------------
    // Load statistics. The hit that follows a fill is the same load as the
    // miss, so it is not counted again.
    // ------------------------------------------------------------------
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_rd_hit && !r_fill_done && (r_hit_count != '1)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_rd_miss && (r_miss_count != '1)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule
